// File: rtl/fp_align_pipe.sv
// Two-stage operand unpack and alignment for the FP adder: stage 1 unpacks and
// orders the operands, stage 2 aligns the smaller mantissa with guard/round/sticky.
module fp_align_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    localparam int W    = 1 + EXP_W + MAN_W,
    localparam int MW   = MAN_W + 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign_large,
    output logic             sign_small,
    output logic             eff_sub,
    output logic             swapped,
    output logic [EXP_W-1:0] exp_out,
    output logic [MW-1:0]    m_large,
    output logic [MW-1:0]    m_small
);

    localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
    localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};

    logic             s1_valid_q, s2_valid_q;
    logic             s2_load_s, in_ready_s;

    logic [EXP_W-1:0] exp_a_s, exp_b_s, eff_a_s, eff_b_s;
    logic [MW-1:0]    mant_a_s, mant_b_s;
    logic             a_large_s;

    logic             s1_sign_l_d, s1_sign_s_d, s1_swapped_d;
    logic [EXP_W-1:0] s1_exp_d, s1_dist_d;
    logic [MW-1:0]    s1_m_large_d, s1_m_small_d;

    logic             s1_sign_l_q, s1_sign_s_q, s1_swapped_q;
    logic [EXP_W-1:0] s1_exp_q, s1_dist_q;
    logic [MW-1:0]    s1_m_large_q, s1_m_small_q;

    logic [2*MW-1:0]  shift_ext_s;
    logic [MW-1:0]    m_small_d;

    logic             sign_large_q, sign_small_q, eff_sub_q, swapped_q;
    logic [EXP_W-1:0] exp_out_q;
    logic [MW-1:0]    m_large_q, m_small_q;

    // Handshake: stage 2 frees up when empty or draining, stage 1 follows it.
    always_comb begin
        s2_load_s  = !s2_valid_q || out_ready;
        in_ready_s = !s1_valid_q || s2_load_s;
    end

    // Unpack both operands and pick the larger magnitude (ties keep A large).
    always_comb begin
        exp_a_s   = a[W-2 -: EXP_W];
        exp_b_s   = b[W-2 -: EXP_W];
        eff_a_s   = (exp_a_s == EXP_ZERO) ? EXP_ONE : exp_a_s;
        eff_b_s   = (exp_b_s == EXP_ZERO) ? EXP_ONE : exp_b_s;
        mant_a_s  = {(exp_a_s != EXP_ZERO), a[MAN_W-1:0], 3'b000};
        mant_b_s  = {(exp_b_s != EXP_ZERO), b[MAN_W-1:0], 3'b000};
        a_large_s = (eff_a_s > eff_b_s) ||
                    ((eff_a_s == eff_b_s) && (a[MAN_W-1:0] >= b[MAN_W-1:0]));
        if (a_large_s) begin
            s1_sign_l_d  = a[W-1];
            s1_sign_s_d  = b[W-1];
            s1_swapped_d = 1'b0;
            s1_exp_d     = eff_a_s;
            s1_dist_d    = eff_a_s - eff_b_s;
            s1_m_large_d = mant_a_s;
            s1_m_small_d = mant_b_s;
        end else begin
            s1_sign_l_d  = b[W-1];
            s1_sign_s_d  = a[W-1];
            s1_swapped_d = 1'b1;
            s1_exp_d     = eff_b_s;
            s1_dist_d    = eff_b_s - eff_a_s;
            s1_m_large_d = mant_b_s;
            s1_m_small_d = mant_a_s;
        end
    end

    // Stage 1 register: unpacked, ordered operands and exponent distance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sign_l_q  <= 1'b0;
            s1_sign_s_q  <= 1'b0;
            s1_swapped_q <= 1'b0;
            s1_exp_q     <= EXP_ZERO;
            s1_dist_q    <= EXP_ZERO;
            s1_m_large_q <= {MW{1'b0}};
            s1_m_small_q <= {MW{1'b0}};
        end else if (in_ready_s) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_l_q  <= s1_sign_l_d;
                s1_sign_s_q  <= s1_sign_s_d;
                s1_swapped_q <= s1_swapped_d;
                s1_exp_q     <= s1_exp_d;
                s1_dist_q    <= s1_dist_d;
                s1_m_large_q <= s1_m_large_d;
                s1_m_small_q <= s1_m_small_d;
            end
        end
    end

    // Align: the low half of the extended shift holds every bit shifted out.
    always_comb begin
        shift_ext_s = {s1_m_small_q, {MW{1'b0}}} >> s1_dist_q;
        if (32'(s1_dist_q) >= 32'(MW)) begin
            m_small_d = {{(MW-1){1'b0}}, |s1_m_small_q};
        end else begin
            m_small_d = {shift_ext_s[2*MW-1:MW+1],
                         shift_ext_s[MW] | (|shift_ext_s[MW-1:0])};
        end
    end

    // Stage 2 register: aligned result, held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q   <= 1'b0;
            sign_large_q <= 1'b0;
            sign_small_q <= 1'b0;
            eff_sub_q    <= 1'b0;
            swapped_q    <= 1'b0;
            exp_out_q    <= EXP_ZERO;
            m_large_q    <= {MW{1'b0}};
            m_small_q    <= {MW{1'b0}};
        end else if (s2_load_s) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sign_large_q <= s1_sign_l_q;
                sign_small_q <= s1_sign_s_q;
                eff_sub_q    <= s1_sign_l_q ^ s1_sign_s_q;
                swapped_q    <= s1_swapped_q;
                exp_out_q    <= s1_exp_q;
                m_large_q    <= s1_m_large_q;
                m_small_q    <= m_small_d;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = s2_valid_q;
    assign sign_large = sign_large_q;
    assign sign_small = sign_small_q;
    assign eff_sub    = eff_sub_q;
    assign swapped    = swapped_q;
    assign exp_out    = exp_out_q;
    assign m_large    = m_large_q;
    assign m_small    = m_small_q;

endmodule

// File: tb/tb_fp_align_pipe.sv
// Self-checking bench for fp_align_pipe: directed plan vectors, random stream
// against an arithmetic reference model, backpressure and mid-stream reset.
module tb_fp_align_pipe;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int MW    = MAN_W + 4;

    typedef struct packed {
        logic             sl;
        logic             ss;
        logic             sub;
        logic             sw;
        logic [EXP_W-1:0] ex;
        logic [MW-1:0]    ml;
        logic [MW-1:0]    ms;
    } res_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     a = '0;
    logic [W-1:0]     b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             sign_large, sign_small, eff_sub, swapped;
    logic [EXP_W-1:0] exp_out;
    logic [MW-1:0]    m_large, m_small;

    int   tests_run = 0;
    int   tests_failed = 0;
    res_t exp_q[$];

    fp_align_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_large(sign_large), .sign_small(sign_small), .eff_sub(eff_sub),
        .swapped(swapped), .exp_out(exp_out), .m_large(m_large), .m_small(m_small)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the unpacked numbers.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        res_t r;
        int ex_x, ex_y, ea, eb, fa, fb, ma, mb, ml, msm, el, es, d, rem;
        bit a_big;
        ex_x = int'(x[W-2 -: EXP_W]);
        ex_y = int'(y[W-2 -: EXP_W]);
        fa = int'(x[MAN_W-1:0]);
        fb = int'(y[MAN_W-1:0]);
        ea = (ex_x == 0) ? 1 : ex_x;
        eb = (ex_y == 0) ? 1 : ex_y;
        ma = (((ex_x != 0) ? (1 << MAN_W) : 0) + fa) * 8;
        mb = (((ex_y != 0) ? (1 << MAN_W) : 0) + fb) * 8;
        a_big = (ea > eb) || (ea == eb && fa >= fb);
        el  = a_big ? ea : eb;
        es  = a_big ? eb : ea;
        ml  = a_big ? ma : mb;
        msm = a_big ? mb : ma;
        d   = el - es;
        r.sl  = a_big ? x[W-1] : y[W-1];
        r.ss  = a_big ? y[W-1] : x[W-1];
        r.sub = r.sl ^ r.ss;
        r.sw  = !a_big;
        r.ex  = EXP_W'(el);
        r.ml  = MW'(ml);
        if (d >= MW) begin
            r.ms = MW'((msm != 0) ? 1 : 0);
        end else begin
            rem  = msm % (1 << d);
            r.ms = MW'((msm / (1 << d)) | ((rem != 0) ? 1 : 0));
        end
        return r;
    endfunction

    function automatic res_t observed();
        return '{sign_large, sign_small, eff_sub, swapped, exp_out, m_large, m_small};
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("exp=%0d ml=%h ms=%h sl=%b ss=%b sub=%b sw=%b",
                         r.ex, r.ml, r.ms, r.sl, r.ss, r.sub, r.sw);
    endfunction

    // One cycle: drive at the falling edge, report which handshakes will fire.
    task automatic step(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic r, output bit fin, output bit fout);
        @(negedge clk);
        in_valid  = v;
        a         = aa;
        b         = bb;
        out_ready = r;
        #1;
        fin  = in_valid && in_ready;
        fout = out_valid && out_ready;
    endtask

    task automatic test_reset();
        res_t zero_r;
        zero_r = '0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || observed() !== zero_r) begin
            tests_failed++;
            $display("FAIL reset_during: out_valid=%b %s, want 0 and all zero", out_valid, fmt(observed()));
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_after: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0]     va[5]  = '{16'h3C00, 16'h3C00, 16'h4C00, 16'h7800, 16'h7800};
        logic [W-1:0]     vb[5]  = '{16'h3800, 16'hBE00, 16'h3C01, 16'h0001, 16'h0000};
        logic [EXP_W-1:0] vex[5] = '{5'd15, 5'd15, 5'd19, 5'd30, 5'd30};
        logic [MW-1:0]    vml[5] = '{14'h2000, 14'h3000, 14'h2000, 14'h2000, 14'h2000};
        logic [MW-1:0]    vms[5] = '{14'h1000, 14'h2000, 14'h0201, 14'h0001, 14'h0000};
        logic             vsw[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        bit fin, fout;
        res_t o, m;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, va[i], vb[i], 1'b1, fin, fout);
            tests_run++;
            if (!fin) begin
                tests_failed++;
                $display("FAIL dir%0d_accept: in_ready=%b, want 1", i, in_ready);
            end
            step(1'b0, '0, '0, 1'b1, fin, fout);
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL dir%0d_early: out_valid=%b, want 0", i, out_valid);
            end
            step(1'b0, '0, '0, 1'b1, fin, fout);
            o = observed();
            m = model(va[i], vb[i]);
            tests_run++;
            if (out_valid !== 1'b1 || o !== m || o.ex !== vex[i] || o.ml !== vml[i] ||
                o.ms !== vms[i] || o.sw !== vsw[i]) begin
                tests_failed++;
                $display("FAIL dir%0d_result: valid=%b %s, want valid=1 %s", i, out_valid, fmt(o), fmt(m));
            end
        end
        step(1'b0, '0, '0, 1'b1, fin, fout);
    endtask

    task automatic test_random();
        bit fin, fout;
        logic [W-1:0] ra, rb;
        res_t e, o;
        int drained;
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 1) == 1) rb[W-2 -: EXP_W] = ra[W-2 -: EXP_W] ^ EXP_W'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) rb[W-2 -: EXP_W] = '0;
            step($urandom_range(0, 9) < 7, ra, rb, $urandom_range(0, 9) < 7, fin, fout);
            if (fout) begin
                o = observed();
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rand_extra: unexpected output %s", fmt(o));
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        tests_failed++;
                        $display("FAIL rand_data: got %s, want %s", fmt(o), fmt(e));
                    end
                end
            end
            if (fin) exp_q.push_back(model(ra, rb));
        end
        drained = 0;
        while (exp_q.size() != 0 && drained < 20) begin
            step(1'b0, '0, '0, 1'b1, fin, fout);
            drained++;
            if (fout) begin
                o = observed();
                e = exp_q.pop_front();
                tests_run++;
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL rand_drain: got %s, want %s", fmt(o), fmt(e));
                end
            end
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rand_lost: %0d results never emerged, want 0", exp_q.size());
        end
        step(1'b0, '0, '0, 1'b1, fin, fout);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] pa[4], pb[4];
        bit fin, fout;
        int idx, outs, cyc;
        res_t o, e;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            pa[i] = W'($urandom);
            pb[i] = W'($urandom);
        end
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, pa[idx], pb[idx], 1'b0, fin, fout);
            if (k >= 2) begin
                o = observed();
                tests_run++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || o !== exp_q[0]) begin
                    tests_failed++;
                    $display("FAIL bp_hold%0d: in_ready=%b out_valid=%b %s, want 0 1 %s",
                             k, in_ready, out_valid, fmt(o), fmt(exp_q[0]));
                end
            end
            if (fin) begin
                exp_q.push_back(model(pa[idx], pb[idx]));
                idx++;
            end
        end
        tests_run++;
        if (idx != 2) begin
            tests_failed++;
            $display("FAIL bp_accepts: %0d accepted while stalled, want 2", idx);
        end
        outs = 0;
        cyc = 0;
        while (outs < 4 && cyc < 20) begin
            step(idx < 4, pa[idx % 4], pb[idx % 4], 1'b1, fin, fout);
            if (cyc == 0) begin
                tests_run++;
                if (!fin) begin
                    tests_failed++;
                    $display("FAIL bp_release_ready: in_ready=%b, want 1", in_ready);
                end
            end
            if (fout) begin
                o = observed();
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL bp_dup: extra output %s", fmt(o));
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        tests_failed++;
                        $display("FAIL bp_order: got %s, want %s", fmt(o), fmt(e));
                    end
                end
                outs++;
            end
            if (fin && idx < 4) begin
                exp_q.push_back(model(pa[idx], pb[idx]));
                idx++;
            end
            cyc++;
        end
        tests_run++;
        if (outs != 4 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_count: %0d outputs %0d pending, want 4 0", outs, exp_q.size());
        end
        step(1'b0, '0, '0, 1'b1, fin, fout);
    endtask

    task automatic test_reset_midstream();
        bit fin, fout;
        res_t zero_r, o, m;
        zero_r = '0;
        step(1'b1, 16'h4C00, 16'h3C01, 1'b0, fin, fout);
        step(1'b1, 16'h3C00, 16'hBE00, 1'b0, fin, fout);
        step(1'b0, '0, '0, 1'b0, fin, fout);
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_full: out_valid=%b in_ready=%b, want 1 0", out_valid, in_ready);
        end
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || observed() !== zero_r) begin
            tests_failed++;
            $display("FAIL rst_async: out_valid=%b %s, want 0 and all zero", out_valid, fmt(observed()));
        end
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 16'h3C00, 16'h3800, 1'b1, fin, fout);
        tests_run++;
        if (!fin || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        step(1'b0, '0, '0, 1'b1, fin, fout);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_stale: out_valid=%b, want 0", out_valid);
        end
        step(1'b0, '0, '0, 1'b1, fin, fout);
        o = observed();
        m = model(16'h3C00, 16'h3800);
        tests_run++;
        if (out_valid !== 1'b1 || o !== m) begin
            tests_failed++;
            $display("FAIL rst_next: valid=%b %s, want valid=1 %s", out_valid, fmt(o), fmt(m));
        end
        step(1'b0, '0, '0, 1'b1, fin, fout);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
